// File: rtl/obi_router_pkg.sv
// Shared types and constants for the OBI data router: MMIO register offsets
// and the response-FIFO entry layout.
package obi_router_pkg;

  localparam logic [3:0] MMIO_EXIT_OFS  = 4'h0;
  localparam logic [3:0] MMIO_PRINT_OFS = 4'h4;
  localparam logic [3:0] MMIO_CYCHI_OFS = 4'h8;

  // Target id field is sized for up to 16 targets so the entry type stays fixed
  localparam int unsigned ID_W = 4;

  typedef struct packed {
    logic            internal;
    logic [ID_W-1:0] id;
    logic [31:0]     rdata;
    logic            err;
  } rsp_entry_t;

endpackage

// File: rtl/obi_router_rsp_fifo.sv
// In-order response tracking FIFO; pointers carry a wrap bit so full and empty
// are told apart without a separate counter.
module obi_router_rsp_fifo
  import obi_router_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  rsp_entry_t wdata,
  input  logic       pop,
  output rsp_entry_t head,
  output logic       full,
  output logic       empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0] wr_idx_r, rd_idx_r;
  logic          wr_wrap_r, rd_wrap_r;
  rsp_entry_t    mem_r [DEPTH];
  logic          push_ok_s, pop_ok_s;

  function automatic logic [PW-1:0] idx_inc(input logic [PW-1:0] idx);
    if (idx == PW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return idx + PW'(1);
    end
  endfunction

  function automatic logic at_last(input logic [PW-1:0] idx);
    return (idx == PW'(DEPTH - 1));
  endfunction

  assign empty     = (wr_idx_r == rd_idx_r) && (wr_wrap_r == rd_wrap_r);
  assign full      = (wr_idx_r == rd_idx_r) && (wr_wrap_r != rd_wrap_r);
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign head      = mem_r[rd_idx_r];

  // Pointer and storage update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx_r  <= '0;
      rd_idx_r  <= '0;
      wr_wrap_r <= 1'b0;
      rd_wrap_r <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (push_ok_s) begin
        mem_r[wr_idx_r] <= wdata;
        wr_idx_r        <= idx_inc(wr_idx_r);
        wr_wrap_r       <= wr_wrap_r ^ at_last(wr_idx_r);
      end
      if (pop_ok_s) begin
        rd_idx_r  <= idx_inc(rd_idx_r);
        rd_wrap_r <= rd_wrap_r ^ at_last(rd_idx_r);
      end
    end
  end

endmodule

// File: rtl/obi_data_router.sv
// Core data-port router: address decode to N targets, in-order response
// return through a tracking FIFO, and the EXIT/PRINT/cycle-counter MMIO block.
module obi_data_router
  import obi_router_pkg::*;
#(
  parameter int unsigned              N_SLV     = 4,
  parameter int unsigned              MAX_OUTST = 2,
  parameter logic [N_SLV-1:0][31:0]   SLV_BASE  = {N_SLV{32'h0}},
  parameter logic [N_SLV-1:0][31:0]   SLV_END   = {N_SLV{32'h0}},
  parameter logic [31:0]              MMIO_BASE = 32'h8000_0000
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        data_req_i,
  output logic                        data_gnt_o,
  input  logic                        data_we_i,
  input  logic [3:0]                  data_be_i,
  input  logic [31:0]                 data_addr_i,
  input  logic [31:0]                 data_wdata_i,
  output logic                        data_rvalid_o,
  output logic [31:0]                 data_rdata_o,
  output logic                        data_err_o,
  output logic [N_SLV-1:0]            slv_req_o,
  output logic [31:0]                 slv_addr_o,
  output logic                        slv_we_o,
  output logic [3:0]                  slv_be_o,
  output logic [31:0]                 slv_wdata_o,
  input  logic [N_SLV-1:0]            slv_gnt_i,
  input  logic [N_SLV-1:0]            slv_rvalid_i,
  input  logic [N_SLV-1:0][31:0]      slv_rdata_i,
  output logic                        exit_valid_o,
  output logic [31:0]                 exit_code_o,
  output logic                        print_valid_o,
  output logic [7:0]                  print_char_o,
  output logic [63:0]                 cycle_count_o,
  output logic                        proto_err_o
);

  logic [31:2] mmio_ofs_s;
  logic        mmio_hit_s;
  logic        slv_hit_s;
  logic [ID_W-1:0] slv_sel_s;
  logic [31:0] mmio_rdata_s;
  logic        wr_exit_s, wr_print_s;
  logic        push_s, full_s, empty_s;
  rsp_entry_t  push_entry_s, head_s;
  logic        rvalid_s, err_s, stray_s;
  logic [31:0] rdata_s;

  logic [63:0] cycle_cnt_r;
  logic        exit_valid_r, print_valid_r, proto_err_r;
  logic [31:0] exit_code_r;
  logic [7:0]  print_char_r;

  assign slv_addr_o  = data_addr_i;
  assign slv_we_o    = data_we_i;
  assign slv_be_o    = data_be_i;
  assign slv_wdata_o = data_wdata_i;

  // Address decode: MMIO window wins, then the lowest-index matching target
  always_comb begin
    mmio_ofs_s = data_addr_i[31:2] - MMIO_BASE[31:2];
    mmio_hit_s = (mmio_ofs_s[31:4] == 28'h0);
    slv_hit_s  = 1'b0;
    slv_sel_s  = '0;
    for (int i = int'(N_SLV) - 1; i >= 0; i--) begin
      if ((data_addr_i >= SLV_BASE[i]) && (data_addr_i < SLV_END[i])) begin
        slv_hit_s = 1'b1;
        slv_sel_s = ID_W'(i);
      end else begin
        slv_hit_s = slv_hit_s;
      end
    end
  end

  // Request steering, grant generation and FIFO push entry
  always_comb begin
    data_gnt_o   = 1'b0;
    slv_req_o    = '0;
    push_s       = 1'b0;
    push_entry_s = '0;
    wr_exit_s    = 1'b0;
    wr_print_s   = 1'b0;
    case (mmio_ofs_s[3:2])
      2'd0:    mmio_rdata_s = cycle_cnt_r[31:0];
      2'd2:    mmio_rdata_s = cycle_cnt_r[63:32];
      default: mmio_rdata_s = 32'h0;
    endcase
    if (data_req_i && !full_s) begin
      if (mmio_hit_s) begin
        data_gnt_o            = 1'b1;
        push_s                = 1'b1;
        push_entry_s.internal = 1'b1;
        push_entry_s.rdata    = data_we_i ? 32'h0 : mmio_rdata_s;
        wr_exit_s  = data_we_i && ({mmio_ofs_s[3:2], 2'b00} == MMIO_EXIT_OFS);
        wr_print_s = data_we_i && ({mmio_ofs_s[3:2], 2'b00} == MMIO_PRINT_OFS);
      end else if (slv_hit_s) begin
        for (int i = 0; i < int'(N_SLV); i++) begin
          if (slv_sel_s == ID_W'(i)) begin
            slv_req_o[i] = 1'b1;
            data_gnt_o   = slv_gnt_i[i];
          end else begin
            slv_req_o[i] = 1'b0;
          end
        end
        push_s          = data_gnt_o;
        push_entry_s.id = slv_sel_s;
      end else begin
        data_gnt_o            = 1'b1;
        push_s                = 1'b1;
        push_entry_s.internal = 1'b1;
        push_entry_s.err      = 1'b1;
      end
    end else begin
      data_gnt_o = 1'b0;
    end
  end

  // Response return from the FIFO head and stray-response detection
  always_comb begin
    rvalid_s = 1'b0;
    rdata_s  = 32'h0;
    err_s    = 1'b0;
    stray_s  = 1'b0;
    if (!empty_s) begin
      if (head_s.internal) begin
        rvalid_s = 1'b1;
        rdata_s  = head_s.rdata;
        err_s    = head_s.err;
      end else begin
        for (int j = 0; j < int'(N_SLV); j++) begin
          if ((head_s.id == ID_W'(j)) && slv_rvalid_i[j]) begin
            rvalid_s = 1'b1;
            rdata_s  = slv_rdata_i[j];
          end else begin
            rvalid_s = rvalid_s;
          end
        end
      end
    end else begin
      rvalid_s = 1'b0;
    end
    for (int j = 0; j < int'(N_SLV); j++) begin
      if (slv_rvalid_i[j] && (empty_s || head_s.internal || (head_s.id != ID_W'(j)))) begin
        stray_s = 1'b1;
      end else begin
        stray_s = stray_s;
      end
    end
  end

  assign data_rvalid_o = rvalid_s;
  assign data_rdata_o  = rdata_s;
  assign data_err_o    = err_s;

  obi_router_rsp_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_rsp_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .push  (push_s),
    .wdata (push_entry_s),
    .pop   (rvalid_s),
    .head  (head_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // MMIO side-effect registers, sticky error flag and cycle counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycle_cnt_r   <= 64'h0;
      exit_valid_r  <= 1'b0;
      exit_code_r   <= 32'h0;
      print_valid_r <= 1'b0;
      print_char_r  <= 8'h0;
      proto_err_r   <= 1'b0;
    end else begin
      cycle_cnt_r   <= cycle_cnt_r + 64'd1;
      print_valid_r <= wr_print_s;
      if (wr_print_s) begin
        print_char_r <= data_wdata_i[7:0];
      end
      if (wr_exit_s) begin
        exit_valid_r <= 1'b1;
        exit_code_r  <= data_wdata_i;
      end
      if (stray_s) begin
        proto_err_r <= 1'b1;
      end
    end
  end

  assign exit_valid_o  = exit_valid_r;
  assign exit_code_o   = exit_code_r;
  assign print_valid_o = print_valid_r;
  assign print_char_o  = print_char_r;
  assign cycle_count_o = cycle_cnt_r;
  assign proto_err_o   = proto_err_r;

endmodule

// File: tb/tb_obi_data_router.sv
// Self-checking bench for obi_data_router: vector table plus hand-written
// sequences, with a response scoreboard checked on every core rvalid.
module tb_obi_data_router;

  localparam logic [31:0] MMIO = 32'h8000_0000;

  logic             clk, rst_n;
  logic             data_req, data_we;
  logic [3:0]       data_be;
  logic [31:0]      data_addr, data_wdata;
  logic             data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0]      data_rdata_o;
  logic [3:0]       slv_req_o, slv_gnt, slv_rvalid;
  logic [31:0]      slv_addr_o, slv_wdata_o;
  logic             slv_we_o;
  logic [3:0]       slv_be_o;
  logic [3:0][31:0] slv_rdata;
  logic             exit_valid_o, print_valid_o, proto_err_o;
  logic [31:0]      exit_code_o;
  logic [7:0]       print_char_o;
  logic [63:0]      cycle_count_o;
  logic [63:0]      tb_cyc;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  exp_req;
    logic        cyclo;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          dly;
  } vec_t;

  rsp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   rv_count = 0;

  obi_data_router #(
    .N_SLV     (4),
    .MAX_OUTST (2),
    .SLV_BASE  ({32'h1000_8000, 32'h3000_0000, 32'h2000_0000, 32'h1000_0000}),
    .SLV_END   ({32'h1002_0000, 32'h3001_0000, 32'h2001_0000, 32'h1001_0000}),
    .MMIO_BASE (MMIO)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .data_req_i    (data_req),
    .data_gnt_o    (data_gnt_o),
    .data_we_i     (data_we),
    .data_be_i     (data_be),
    .data_addr_i   (data_addr),
    .data_wdata_i  (data_wdata),
    .data_rvalid_o (data_rvalid_o),
    .data_rdata_o  (data_rdata_o),
    .data_err_o    (data_err_o),
    .slv_req_o     (slv_req_o),
    .slv_addr_o    (slv_addr_o),
    .slv_we_o      (slv_we_o),
    .slv_be_o      (slv_be_o),
    .slv_wdata_o   (slv_wdata_o),
    .slv_gnt_i     (slv_gnt),
    .slv_rvalid_i  (slv_rvalid),
    .slv_rdata_i   (slv_rdata),
    .exit_valid_o  (exit_valid_o),
    .exit_code_o   (exit_code_o),
    .print_valid_o (print_valid_o),
    .print_char_o  (print_char_o),
    .cycle_count_o (cycle_count_o),
    .proto_err_o   (proto_err_o)
  );

  // Targets always accept in the request cycle
  assign slv_gnt = slv_req_o;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference cycle count
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cyc <= 64'd0;
    else        tb_cyc <= tb_cyc + 64'd1;
  end

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Scoreboard: every core response is compared against the oldest expectation
  always @(negedge clk) begin
    #1;
    if (rst_n && data_rvalid_o) begin
      rv_count++;
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        chk("rsp_rdata", data_rdata_o, e.rdata);
        chk("rsp_err", data_err_o, e.err);
      end
    end
  end

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic exp_err, input logic cyclo,
                       output int waits);
    bit got;
    got   = 1'b0;
    waits = 0;
    @(posedge clk); #1;
    data_req = 1'b1; data_we = we; data_addr = addr; data_wdata = wdata; data_be = 4'hF;
    for (int i = 0; i < 16 && !got; i++) begin
      @(negedge clk);
      if (data_gnt_o) begin
        got = 1'b1;
        exp_q.push_back('{cyclo ? tb_cyc[31:0] : exp_rd, exp_err});
      end else begin
        waits++;
        @(posedge clk); #1;
      end
    end
    chk("gnt_seen", got, 1'b1);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    data_req = 1'b0; data_we = 1'b0; data_addr = 32'h0; data_wdata = 32'h0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #2;
      if (exp_q.size() == 0) break;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic run_vec(input vec_t v);
    int waits, n0, idx;
    issue(v.we, v.addr, v.wdata, v.exp_rd, v.exp_err, v.cyclo, waits);
    chk("gnt_latency", waits, 0);
    chk("decode", slv_req_o, v.exp_req);
    chk("bcast_addr", slv_addr_o, v.addr);
    chk("bcast_wdata", {slv_we_o, slv_wdata_o}, {v.we, v.wdata});
    n0  = rv_count;
    idx = 0;
    for (int i = 0; i < 4; i++) if (v.exp_req[i]) idx = i;
    idle();
    if (v.dly == 0) begin
      @(negedge clk);
      chk("int_latency", data_rvalid_o, 1'b1);
    end else begin
      repeat (v.dly - 1) begin @(posedge clk); #1; end
      slv_rvalid[idx] = 1'b1; slv_rdata[idx] = v.exp_rd;
      @(posedge clk); #1;
      slv_rvalid = '0; slv_rdata = '0;
    end
    drain();
    @(negedge clk); #2;
    chk("rvalid_count", rv_count - n0, 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_gnt_rvalid_err"}, {data_gnt_o, data_rvalid_o, data_err_o}, 3'b000);
    chk({tag, "_rdata"}, data_rdata_o, 32'h0);
    chk({tag, "_slv_req"}, slv_req_o, 4'h0);
    chk({tag, "_exit"}, {exit_valid_o, exit_code_o}, 33'h0);
    chk({tag, "_print"}, {print_valid_o, print_char_o}, 9'h0);
    chk({tag, "_cycle"}, cycle_count_o, 64'h0);
    chk({tag, "_proto"}, proto_err_o, 1'b0);
  endtask

  vec_t vecs[15];

  initial begin
    int waits;
    vecs[0]  = '{1'b0, 32'h2000_0004, 32'h0, 4'b0010, 1'b0, 32'hDEAD_BEEF, 1'b0, 3};
    vecs[1]  = '{1'b0, 32'h1000_0010, 32'h0, 4'b0001, 1'b0, 32'h1111_1111, 1'b0, 1};
    vecs[2]  = '{1'b0, 32'h1000_8000, 32'h0, 4'b0001, 1'b0, 32'h2222_2222, 1'b0, 2};
    vecs[3]  = '{1'b0, 32'h1001_0000, 32'h0, 4'b1000, 1'b0, 32'h3333_3333, 1'b0, 1};
    vecs[4]  = '{1'b1, 32'h3000_0000, 32'hA5A5_0001, 4'b0100, 1'b0, 32'h0, 1'b0, 2};
    vecs[5]  = '{1'b0, 32'h3000_FFFC, 32'h0, 4'b0100, 1'b0, 32'h4444_4444, 1'b0, 1};
    vecs[6]  = '{1'b0, 32'h3001_0000, 32'h0, 4'b0000, 1'b0, 32'h0, 1'b1, 0};
    vecs[7]  = '{1'b0, 32'h0000_0000, 32'h0, 4'b0000, 1'b0, 32'h0, 1'b1, 0};
    vecs[8]  = '{1'b0, MMIO + 32'h0, 32'h0, 4'b0000, 1'b1, 32'h0, 1'b0, 0};
    vecs[9]  = '{1'b0, MMIO + 32'h4, 32'h0, 4'b0000, 1'b0, 32'h0, 1'b0, 0};
    vecs[10] = '{1'b0, MMIO + 32'h8, 32'h0, 4'b0000, 1'b0, 32'h0, 1'b0, 0};
    vecs[11] = '{1'b0, MMIO + 32'hC, 32'h0, 4'b0000, 1'b0, 32'h0, 1'b0, 0};
    vecs[12] = '{1'b1, MMIO + 32'hC, 32'h1234_5678, 4'b0000, 1'b0, 32'h0, 1'b0, 0};
    vecs[13] = '{1'b0, MMIO + 32'h10, 32'h0, 4'b0000, 1'b0, 32'h0, 1'b1, 0};
    vecs[14] = '{1'b0, 32'h7FFF_FFFC, 32'h0, 4'b0000, 1'b0, 32'h0, 1'b1, 0};

    rst_n = 1'b0; data_req = 1'b0; data_we = 1'b0; data_be = 4'h0;
    data_addr = 32'h0; data_wdata = 32'h0; slv_rvalid = '0; slv_rdata = '0;
    #23;
    check_outputs_zero("reset");
    @(negedge clk); #2 rst_n = 1'b1;

    foreach (vecs[k]) run_vec(vecs[k]);
    chk("reserved_write_no_exit", exit_valid_o, 1'b0);

    // PRINT then EXIT writes
    issue(1'b1, MMIO + 32'h4, 32'h0000_0041, 32'h0, 1'b0, 1'b0, waits);
    chk("print_before", print_valid_o, 1'b0);
    idle();
    @(negedge clk);
    chk("print_pulse", {print_valid_o, print_char_o}, {1'b1, 8'h41});
    @(negedge clk);
    chk("print_single", print_valid_o, 1'b0);
    issue(1'b1, MMIO + 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, waits);
    chk("exit_before", exit_valid_o, 1'b0);
    idle();
    @(negedge clk);
    chk("exit_set", {exit_valid_o, exit_code_o}, {1'b1, 32'h0});
    issue(1'b1, MMIO + 32'h0, 32'h0000_0055, 32'h0, 1'b0, 1'b0, waits);
    idle();
    @(negedge clk);
    chk("exit_update", {exit_valid_o, exit_code_o, print_valid_o}, {1'b1, 32'h55, 1'b0});
    drain();

    // Full FIFO back-pressure and in-order return
    issue(1'b0, 32'h1000_0000, 32'h0, 32'hAAAA_0001, 1'b0, 1'b0, waits);
    issue(1'b0, 32'h1000_0004, 32'h0, 32'hAAAA_0002, 1'b0, 1'b0, waits);
    chk("b2b_gnt", waits, 0);
    @(posedge clk); #1 data_addr = 32'h3000_0010;
    @(negedge clk);
    chk("full_slv_req", slv_req_o, 4'h0);
    chk("full_gnt_ext", data_gnt_o, 1'b0);
    @(posedge clk); #1 data_addr = MMIO;
    @(negedge clk);
    chk("full_gnt_mmio", data_gnt_o, 1'b0);
    @(posedge clk); #1 slv_rvalid[0] = 1'b1; slv_rdata[0] = 32'hAAAA_0001;
    @(negedge clk);
    chk("full_gnt_on_pop", data_gnt_o, 1'b0);
    @(posedge clk); #1 slv_rvalid = '0; slv_rdata = '0;
    @(negedge clk);
    chk("gnt_after_pop", data_gnt_o, 1'b1);
    if (data_gnt_o) exp_q.push_back('{tb_cyc[31:0], 1'b0});
    @(posedge clk); #1;
    data_req = 1'b0; slv_rvalid[0] = 1'b1; slv_rdata[0] = 32'hAAAA_0002;
    @(posedge clk); #1 slv_rvalid = '0; slv_rdata = '0;
    @(negedge clk);
    chk("mmio_after_ext", data_rvalid_o, 1'b1);
    drain();

    // Stray response from a target that is not at the head
    issue(1'b0, 32'h1000_0020, 32'h0, 32'hBBBB_0000, 1'b0, 1'b0, waits);
    idle();
    chk("proto_before", proto_err_o, 1'b0);
    slv_rvalid[2] = 1'b1; slv_rdata[2] = 32'hBAD0_BAD0;
    @(negedge clk);
    chk("stray_no_rvalid", data_rvalid_o, 1'b0);
    @(posedge clk); #1 slv_rvalid = '0; slv_rdata = '0;
    @(negedge clk);
    chk("proto_set", proto_err_o, 1'b1);
    @(posedge clk); #1 slv_rvalid[0] = 1'b1; slv_rdata[0] = 32'hBBBB_0000;
    @(posedge clk); #1 slv_rvalid = '0; slv_rdata = '0;
    drain();
    @(negedge clk);
    chk("proto_sticky", proto_err_o, 1'b1);

    // Asynchronous reset with an access outstanding
    issue(1'b0, 32'h2000_0100, 32'h0, 32'hCCCC_0000, 1'b0, 1'b0, waits);
    idle();
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    exp_q.delete();
    @(posedge clk); #1 slv_rvalid[1] = 1'b1; slv_rdata[1] = 32'hCCCC_0000;
    @(negedge clk);
    chk("proto_in_reset", proto_err_o, 1'b0);
    @(posedge clk); #1 slv_rvalid = '0; slv_rdata = '0;
    @(negedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    chk("cycle_restart", cycle_count_o, 64'd1);
    @(posedge clk); #1 slv_rvalid[1] = 1'b1; slv_rdata[1] = 32'hCCCC_0000;
    @(negedge clk);
    chk("late_rsp_dropped", data_rvalid_o, 1'b0);
    @(posedge clk); #1 slv_rvalid = '0; slv_rdata = '0;
    @(negedge clk);
    chk("proto_after_release", proto_err_o, 1'b1);
    run_vec(vecs[5]);
    run_vec(vecs[8]);
    @(negedge clk);
    chk("cycle_count", cycle_count_o, tb_cyc);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
